// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/freeze controller for the image-filter pipeline (PC, IF/ID, ID/EX, EX/MEM).
// Define HAZARD_PERF_EN to add the stall_cnt / flush_cnt performance counters.
module pipe_hazard_ctrl #(
  parameter logic [3:0]  LOAD_OPCODE      = 4'b1000,
  parameter int          LOAD_STALL_CYC   = 1,
  parameter int          BRANCH_FLUSH_CYC = 2,
  parameter logic [15:0] RS_USED_MASK     = 16'hFFFD,
  parameter logic [7:0]  MEM_TIMEOUT      = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] id_opcode,
  input  logic [3:0] id_rp,
  input  logic [3:0] id_rs,
  input  logic       ex_mem_read,
  input  logic [3:0] ex_rg,
  input  logic       ex_branch_taken,
  input  logic       mem_busy,
  output logic       pc_we,
  output logic       if_id_we,
  output logic       if_id_flush,
  output logic       id_ex_we,
  output logic       id_ex_bubble,
  output logic       ex_mem_we,
  output logic [1:0] ctrl_state,
  output logic       mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    FLUSH  = 2'd2,
    MWAIT  = 2'd3
  } state_t;

  localparam logic [2:0] LOAD_CNT_INIT  = 3'(LOAD_STALL_CYC - 1);
  localparam logic [2:0] FLUSH_CNT_INIT = 3'(BRANCH_FLUSH_CYC - 1);

  state_t     state, state_nx, ret_state, ret_nx, eff_state;
  logic [2:0] cnt, cnt_nx;
  logic [7:0] tmo, tmo_inc;
  logic       hz;

  assign hz = ex_mem_read &
              ((ex_rg == id_rp) | (RS_USED_MASK[id_opcode] & (ex_rg == id_rs)));
  assign tmo_inc    = (tmo == 8'hFF) ? tmo : tmo + 8'd1;
  assign ctrl_state = state;
  // Leaving MWAIT behaves exactly like the interrupted state with its frozen count.
  assign eff_state  = (state == MWAIT) ? ret_state : state;

  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_we     = 1'b1;
    id_ex_bubble = 1'b0;
    ex_mem_we    = 1'b1;
    state_nx     = state;
    cnt_nx       = cnt;
    ret_nx       = ret_state;
    if (rst) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (mem_busy) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
      state_nx  = MWAIT;
      if (state != MWAIT) ret_nx = state;
    end else begin
      state_nx = eff_state;
      case (eff_state)
        LSTALL: begin
          pc_we        = 1'b0;
          if_id_we     = 1'b0;
          id_ex_bubble = 1'b1;
          if (cnt <= 3'd1) begin
            cnt_nx   = 3'd0;
            state_nx = RUN;
          end else begin
            cnt_nx = cnt - 3'd1;
          end
        end
        FLUSH: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          if (cnt <= 3'd1) begin
            cnt_nx   = 3'd0;
            state_nx = RUN;
          end else begin
            cnt_nx = cnt - 3'd1;
          end
        end
        RUN: begin
          if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            cnt_nx       = FLUSH_CNT_INIT;
            state_nx     = (FLUSH_CNT_INIT != 3'd0) ? FLUSH : RUN;
          end else if (hz) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
            cnt_nx       = LOAD_CNT_INIT;
            state_nx     = (LOAD_CNT_INIT != 3'd0) ? LSTALL : RUN;
          end
        end
        default: state_nx = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      cnt         <= 3'd0;
      ret_state   <= RUN;
      tmo         <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      ret_state <= ret_nx;
      if (state == MWAIT && mem_busy) begin
        tmo <= tmo_inc;
        if (tmo_inc >= MEM_TIMEOUT) mem_timeout <= 1'b1;
      end else begin
        tmo <= 8'd0;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (!pc_we && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (if_id_flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule
